imem_loader: RTL and testbench

Parametrised synchronous instruction memory with a streaming program-load port. It replaces the fixed-program combinational ROM in the fetch stage. Programs are written word-by-word over a valid/ready loader interface, and fetches return a registered instruction one cycle later. Locations past the loaded program length, and illegal addresses, read back as a NOP.

---
 rtl/imem_loader.sv | 186 ++++++++++++++++++
 tb/tb_imem_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: synchronous instruction memory with a streaming program-load port.
// Fetches return a registered word one cycle after the request. Words beyond the
// loaded program length read back as NOP. Misaligned or out-of-range addresses
// read back as NOP and raise addr_err.
// Optional build macro IMEM_BOOT_PROG_EN: reset exposes a built-in factorial-of-7
// boot program of 9 words. Any load session replaces it.
module imem_loader #(
  parameter int               WIDTH = 32,
  parameter int               DEPTH = 8,
  parameter logic [WIDTH-1:0] NOP   = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_en,
  input  logic [WIDTH-1:0] fetch_addr,
  output logic [WIDTH-1:0] instr,
  output logic             instr_valid,
  output logic             addr_err,
  input  logic             ld_start,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             ld_last,
  output logic             ld_done,
  output logic             ld_trunc,
  output logic [DEPTH:0]   ld_count,
  output logic             busy
);

  localparam int WORDS = 1 << DEPTH;

`ifdef IMEM_BOOT_PROG_EN
  localparam int             BOOT_LEN = 9;
  localparam logic [DEPTH:0] CNT_RST  = (DEPTH+1)'(BOOT_LEN);

  // Factorial-of-7 boot image. Indices past the image return NOP.
  function automatic logic [WIDTH-1:0] boot_word(input logic [DEPTH-1:0] idx);
    case (idx)
      DEPTH'(0): boot_word = WIDTH'(32'h00008020);
      DEPTH'(1): boot_word = WIDTH'(32'h20100007);
      DEPTH'(2): boot_word = WIDTH'(32'h00008820);
      DEPTH'(3): boot_word = WIDTH'(32'h20110001);
      DEPTH'(4): boot_word = WIDTH'(32'h12000003);
      DEPTH'(5): boot_word = WIDTH'(32'h0230881C);
      DEPTH'(6): boot_word = WIDTH'(32'h2210FFFF);
      DEPTH'(7): boot_word = WIDTH'(32'h08000004);
      DEPTH'(8): boot_word = WIDTH'(32'hAC110000);
      default:   boot_word = NOP;
    endcase
  endfunction
`else
  localparam logic [DEPTH:0] CNT_RST = '0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] mem [WORDS];
  logic [DEPTH-1:0] ptr;
  logic             ld_acc;
  logic             ptr_full;
  logic             sess_start;
  logic             fetch_ok;
  logic [DEPTH-1:0] idx;
  logic             bad_addr;
  logic             in_prog;
  logic [WIDTH-1:0] mem_rd;
  logic [WIDTH-1:0] rd_word;

`ifdef IMEM_BOOT_PROG_EN
  logic             boot_sel;
`endif

  assign ld_acc     = ld_valid && ld_ready;
  assign ptr_full   = &ptr;
  assign sess_start = (state == IDLE) && ld_start;
  assign fetch_ok   = fetch_en && (state != LOAD);
  assign idx        = fetch_addr[DEPTH+1:2];

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state: a session ends on the last word or when the array is full
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ld_start) state_nxt = LOAD;
      LOAD:    if (ld_acc && (ld_last || ptr_full)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs decoded from the current state
  always_comb begin
    ld_ready = 1'b0;
    busy     = 1'b0;
    ld_done  = 1'b0;
    case (state)
      LOAD: begin
        ld_ready = 1'b1;
        busy     = 1'b1;
      end
      DONE:    ld_done = 1'b1;
      default: ;
    endcase
  end

  // Load bookkeeping: write pointer, valid-word count and truncation flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      ld_count <= CNT_RST;
      ld_trunc <= 1'b0;
    end else if (sess_start) begin
      ptr      <= '0;
      ld_count <= '0;
      ld_trunc <= 1'b0;
    end else if (ld_acc) begin
      ptr      <= ptr + DEPTH'(1);
      ld_count <= {1'b0, ptr} + (DEPTH+1)'(1);
      if (ptr_full && !ld_last) begin
        ld_trunc <= 1'b1;
      end
    end
  end

`ifdef IMEM_BOOT_PROG_EN
  // Boot image stays visible until the first load session starts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      boot_sel <= 1'b1;
    end else if (sess_start) begin
      boot_sel <= 1'b0;
    end
  end

  assign mem_rd = boot_sel ? boot_word(idx) : mem[idx];
`else
  assign mem_rd = mem[idx];
`endif

  // Program storage; contents are never reset, ld_count alone gates validity
  always_ff @(posedge clk) begin
    if (ld_acc) begin
      mem[ptr] <= ld_data;
    end
  end

  // Fetch decode: illegal addresses and unloaded words both resolve to NOP
  always_comb begin
    bad_addr = (fetch_addr[1:0] != 2'b00) || ((fetch_addr >> (DEPTH + 2)) != '0);
    in_prog  = ({1'b0, idx} < ld_count);
    rd_word  = NOP;
    if (!bad_addr && in_prog) begin
      rd_word = mem_rd;
    end
  end

  // Fetch output register; instr and addr_err hold when no fetch is serviced
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr       <= NOP;
      instr_valid <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      instr_valid <= fetch_ok;
      if (fetch_ok) begin
        instr    <= rd_word;
        addr_err <= bad_addr;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader. A reference model predicts
// each fetch result when the request is driven; the prediction is queued and
// compared when the registered result appears one cycle later.
module tb_imem_loader;

  localparam int          WIDTH = 32;
  localparam int          DEPTH = 8;
  localparam int          CAP   = 1 << DEPTH;
  localparam logic [31:0] NOP   = 32'h00000000;
`ifdef IMEM_BOOT_PROG_EN
  localparam int          RST_CNT = 9;
`else
  localparam int          RST_CNT = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             fetch_en = 1'b0;
  logic [WIDTH-1:0] fetch_addr = '0;
  logic [WIDTH-1:0] instr;
  logic             instr_valid;
  logic             addr_err;
  logic             ld_start = 1'b0;
  logic             ld_valid = 1'b0;
  logic             ld_ready;
  logic [WIDTH-1:0] ld_data = '0;
  logic             ld_last = 1'b0;
  logic             ld_done;
  logic             ld_trunc;
  logic [DEPTH:0]   ld_count;
  logic             busy;

  imem_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_en    (fetch_en),
    .fetch_addr  (fetch_addr),
    .instr       (instr),
    .instr_valid (instr_valid),
    .addr_err    (addr_err),
    .ld_start    (ld_start),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .ld_done     (ld_done),
    .ld_trunc    (ld_trunc),
    .ld_count    (ld_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        vld;
    logic        err;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mmem [CAP];
  int          mcnt;
  logic [31:0] minstr;
  logic        merr;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Restore the model to the post-reset memory picture
  task automatic model_reset();
    mcnt   = RST_CNT;
    minstr = NOP;
    merr   = 1'b0;
`ifdef IMEM_BOOT_PROG_EN
    mmem[0] = 32'h00008020; mmem[1] = 32'h20100007; mmem[2] = 32'h00008820;
    mmem[3] = 32'h20110001; mmem[4] = 32'h12000003; mmem[5] = 32'h0230881C;
    mmem[6] = 32'h2210FFFF; mmem[7] = 32'h08000004; mmem[8] = 32'hAC110000;
`endif
  endtask

  // Predict a fetch result and queue it; svc=0 means the fetch is ignored
  task automatic push_fetch(input logic [31:0] a, input bit svc);
    exp_t e;
    logic [DEPTH-1:0] wi;
    wi = a[DEPTH+1:2];
    if (!svc) begin
      e.vld = 1'b0; e.instr = minstr; e.err = merr;
    end else begin
      e.vld = 1'b1;
      if (a[1:0] != 2'b00 || (a >> (DEPTH + 2)) != 0) begin
        e.instr = NOP; e.err = 1'b1;
      end else if (int'(wi) >= mcnt) begin
        e.instr = NOP; e.err = 1'b0;
      end else begin
        e.instr = mmem[wi]; e.err = 1'b0;
      end
      minstr = e.instr;
      merr   = e.err;
    end
    sbq.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    check({tag, "_sbq"}, sbq.size(), 1);
    if (sbq.size() == 0) return;
    e = sbq.pop_front();
    check({tag, "_valid"}, instr_valid, e.vld);
    check({tag, "_instr"}, instr, e.instr);
    check({tag, "_err"}, addr_err, e.err);
  endtask

  task automatic fetch(input logic [31:0] a, input bit svc, input string tag);
    fetch_en   = 1'b1;
    fetch_addr = a;
    push_fetch(a, svc);
    tick();
    fetch_en = 1'b0;
    check_out(tag);
  endtask

  // Full load session; pat=1 loads k*11111111, else random words. A fetch
  // is made during LOAD (ignored) and in DONE (sees the new program).
  task automatic load(input int n, input bit last_on_end, input bit pat, input bit co_fetch);
    ld_start = 1'b1;
    if (co_fetch) begin
      fetch_en = 1'b1; fetch_addr = '0; push_fetch(32'h0, 1'b1);
    end
    tick();
    ld_start = 1'b0;
    fetch_en = 1'b0;
    if (co_fetch) check_out("co_fetch");
    mcnt = 0;
    check("busy_load", busy, 1);
    check("ready_load", ld_ready, 1);
    check("count_clr", ld_count, 0);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = pat ? 32'h11111111 * (i + 1) : $urandom;
      ld_last  = last_on_end && (i == n - 1);
      ld_start = pat && (i == 1);
      if (i == 0) begin
        fetch_en = 1'b1; fetch_addr = '0; push_fetch(32'h0, 1'b0);
      end
      tick();
      fetch_en = 1'b0;
      if (i == 0) check_out("fetch_in_load");
      mmem[i] = ld_data;
      mcnt    = i + 1;
      check("ld_count", ld_count, mcnt);
    end
    ld_valid = 1'b0; ld_last = 1'b0; ld_start = 1'b0;
    check("done_pulse", ld_done, 1);
    check("ready_done", ld_ready, 0);
    check("busy_done", busy, 0);
    check("trunc", ld_trunc, !last_on_end && n == CAP);
    fetch(32'(4 * (n - 1)), 1'b1, "fetch_in_done");
    check("done_low", ld_done, 0);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    model_reset();
    tick();
    tick();
    check("rst_instr", instr, NOP);
    check("rst_valid", instr_valid, 0);
    check("rst_err", addr_err, 0);
    check("rst_ready", ld_ready, 0);
    check("rst_done", ld_done, 0);
    check("rst_trunc", ld_trunc, 0);
    check("rst_count", ld_count, RST_CNT);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    fetch(32'h0, 1'b1, "post_rst_0");
    fetch(32'h20, 1'b1, "post_rst_20");
    fetch(32'h6, 1'b1, "misalign");
    fetch(32'h400, 1'b1, "out_of_range");
    tick();
    check("hold_valid", instr_valid, 0);
    check("hold_instr", instr, minstr);

    load(3, 1'b1, 1'b1, 1'b0);
    fetch(32'h0, 1'b1, "f0");
    fetch(32'h4, 1'b1, "f4");
    fetch(32'h8, 1'b1, "f8");
    fetch(32'hC, 1'b1, "fC");
    fetch(32'h80000000, 1'b1, "high_bit");

    load(CAP, 1'b0, 1'b0, 1'b1);
    check("trunc_idle", ld_trunc, 1);
    check("count_full", ld_count, CAP);
    for (int k = 0; k < 6; k++) begin
      fetch(32'($urandom_range(0, CAP - 1) * 4), 1'b1, "full_rand");
    end
    fetch(32'h3FC, 1'b1, "full_last");
    fetch(32'h400, 1'b1, "full_oor");

    load(2, 1'b1, 1'b1, 1'b1);
    check("trunc_cleared", ld_trunc, 0);
    fetch(32'h4, 1'b1, "reload_4");
    fetch(32'h8, 1'b1, "reload_8");

    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; ld_data = $urandom; ld_last = 1'b0;
      tick();
      mmem[i] = ld_data;
    end
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_ready", ld_ready, 0);
    check("abort_count", ld_count, RST_CNT);
    check("abort_instr", instr, NOP);
    model_reset();
    sbq.delete();
    ld_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    fetch(32'h0, 1'b1, "abort_f0");
    fetch(32'h4, 1'b1, "abort_f4");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
